// File: rtl/bus_arbiter.sv
// bus_arbiter: LSU-priority arbiter sharing one Avalon-MM memory port between IFU and LSU, with IFU starvation bound
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            ifu_bus_read,
  input  logic [AW-1:0]   ifu_bus_address,
  output logic            ifu_bus_waitrequest,
  output logic [DW-1:0]   ifu_bus_readdata,
  output logic            ifu_bus_readdatavalid,
  input  logic            lsu_bus_read,
  input  logic            lsu_bus_write,
  input  logic [AW-1:0]   lsu_bus_address,
  input  logic [DW-1:0]   lsu_bus_writedata,
  input  logic [DW/8-1:0] lsu_bus_byteenable,
  output logic            lsu_bus_waitrequest,
  output logic [DW-1:0]   lsu_bus_readdata,
  output logic            lsu_bus_readdatavalid,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_writedata,
  output logic [DW/8-1:0] mem_byteenable,
  input  logic            mem_waitrequest,
  input  logic [DW-1:0]   mem_readdata,
  input  logic            mem_readdatavalid,
  output logic            owner
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;
  state_t state;
  logic owner_is_write;
  logic [SW-1:0] starve_cnt;
  logic lsu_req, ifu_req, ifu_win, in_cmd, rd_done;
  assign lsu_req = lsu_bus_read | lsu_bus_write;
  assign ifu_req = ifu_bus_read;
  assign ifu_win = ifu_req & (~lsu_req | (starve_cnt == SW'(STARVE_LIMIT)));
  assign in_cmd = state == CMD;
  assign rd_done = (state == RDATA) & mem_readdatavalid;
  // simultaneous LSU read+write is handled as a write
  assign mem_read = in_cmd & (owner ? ifu_bus_read : lsu_bus_read & ~lsu_bus_write);
  assign mem_write = in_cmd & ~owner & lsu_bus_write;
  assign mem_address = owner ? ifu_bus_address : lsu_bus_address;
  assign mem_writedata = lsu_bus_writedata;
  assign mem_byteenable = owner ? '1 : lsu_bus_byteenable;
  assign ifu_bus_waitrequest = ~(in_cmd & owner) | mem_waitrequest;
  assign lsu_bus_waitrequest = ~(in_cmd & ~owner) | mem_waitrequest;
  assign ifu_bus_readdata = mem_readdata;
  assign lsu_bus_readdata = mem_readdata;
  assign ifu_bus_readdatavalid = rd_done & owner;
  assign lsu_bus_readdatavalid = rd_done & ~owner;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      owner <= 1'b0;
      owner_is_write <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_win | lsu_req) begin
            owner <= ifu_win;
            owner_is_write <= ~ifu_win & lsu_bus_write;
            state <= CMD;
          end
          starve_cnt <= ifu_win ? '0 :
                        (ifu_req & (starve_cnt != SW'(STARVE_LIMIT))) ? starve_cnt + SW'(1) : starve_cnt;
        end
        CMD: if (!mem_waitrequest) state <= owner_is_write ? IDLE : RDATA;
        RDATA: if (mem_readdatavalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
